// File: rtl/dmni_mem_arbiter.sv
// rtl/dmni_mem_arbiter.sv - round-robin shared-memory arbiter for the DMNI requesters
// Optional per-grant burst limit: define DMNI_ARB_BURST_LIMIT_EN.

module dmni_mem_arbiter #(
  parameter int N_REQ     = 3,
  parameter int MAX_BURST = 16,
  localparam int OW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ*4-1:0] we_i,
  input  logic [N_REQ*32-1:0] addr_i,
  input  logic [N_REQ*32-1:0] data_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic [N_REQ-1:0]   rvalid_o,
  output logic [31:0]        rdata_o,
  output logic [3:0]         mem_we_o,
  output logic [31:0]        mem_addr_o,
  output logic [31:0]        mem_data_o,
  input  logic [31:0]        mem_data_i,
  output logic [OW-1:0]      owner_o,
  output logic               busy_o
);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t           state, state_n;
  logic [OW-1:0]    owner, owner_n;
  logic [OW-1:0]    last_owner, last_n;
  logic             rd_pend, rd_pend_n;
  logic [OW-1:0]    rd_idx;
  logic             beat;
  logic [N_REQ-1:0] others;

  logic [3:0]  we_arr   [N_REQ];
  logic [31:0] addr_arr [N_REQ];
  logic [31:0] data_arr [N_REQ];

`ifdef DMNI_ARB_BURST_LIMIT_EN
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  logic [BW-1:0] beat_cnt, cnt_n;
`endif

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      we_arr[k]   = we_i[k*4 +: 4];
      addr_arr[k] = addr_i[k*32 +: 32];
      data_arr[k] = data_i[k*32 +: 32];
    end
  end

  // Walk from the farthest candidate to the nearest so the nearest one after 'last' wins.
  function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] mask,
                                            input logic [OW-1:0]    last);
    logic [OW-1:0] pick;
    int            idx;
    pick = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = (int'(last) + i) % N_REQ;
      if (mask[OW'(idx)]) pick = OW'(idx);
    end
    return pick;
  endfunction

  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last_owner;
    beat    = 1'b0;
    others  = req_i;
    others[owner] = 1'b0;
`ifdef DMNI_ARB_BURST_LIMIT_EN
    cnt_n = beat_cnt;
`endif
    case (state)
      IDLE: begin
        if (|req_i) begin
          state_n = OWNED;
          owner_n = rr_pick(req_i, last_owner);
`ifdef DMNI_ARB_BURST_LIMIT_EN
          cnt_n = '0;
`endif
        end
      end
      OWNED: begin
        beat = req_i[owner];
        if (!beat) begin
          last_n = owner;
          if (|others) owner_n = rr_pick(others, owner);
          else         state_n = IDLE;
`ifdef DMNI_ARB_BURST_LIMIT_EN
          cnt_n = '0;
`endif
        end
`ifdef DMNI_ARB_BURST_LIMIT_EN
        else if (beat_cnt == BW'(MAX_BURST - 1)) begin
          // Last beat of the allowance: hand over only if someone else is waiting.
          cnt_n = '0;
          if (|others) begin
            last_n  = owner;
            owner_n = rr_pick(others, owner);
          end
        end else begin
          cnt_n = beat_cnt + 1'b1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  assign rd_pend_n = beat && (we_arr[owner] == 4'h0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OW'(N_REQ - 1);
      rd_pend    <= 1'b0;
      rd_idx     <= '0;
`ifdef DMNI_ARB_BURST_LIMIT_EN
      beat_cnt   <= '0;
`endif
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_owner <= last_n;
      rd_pend    <= rd_pend_n;
      rd_idx     <= owner;
`ifdef DMNI_ARB_BURST_LIMIT_EN
      beat_cnt   <= cnt_n;
`endif
    end
  end

  // Outputs are forced to zero while reset is held, independent of register contents.
  always_comb begin
    gnt_o      = '0;
    rvalid_o   = '0;
    rdata_o    = '0;
    mem_we_o   = '0;
    mem_addr_o = '0;
    mem_data_o = '0;
    owner_o    = '0;
    busy_o     = 1'b0;
    if (!rst_i) begin
      busy_o  = (state == OWNED);
      owner_o = owner;
      if (beat) begin
        gnt_o[owner] = 1'b1;
        mem_we_o     = we_arr[owner];
        mem_addr_o   = addr_arr[owner];
        mem_data_o   = data_arr[owner];
      end
      if (rd_pend) begin
        rvalid_o[rd_idx] = 1'b1;
        rdata_o          = mem_data_i;
      end
    end
  end

endmodule
